mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch requester (IF) and the data requester (MEM stage) of the five-stage pipeline.
- Arbitrates between them, sequences each transaction through a small FSM, and returns read data with a one-cycle valid pulse.
- The pipeline uses grant/valid to stall IF or MEM.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 2, memory access cycles (legal 1..7); mem_rdata is valid in the last access cycle.
- MAX_WAIT, 4, IF wait cycles before forced IF priority (fair build only; legal 1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; hold until if_gnt, may withdraw before grant.
- if_addr  in  AW  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse, if_rdata valid.
- if_rdata  out  DW  fetched instruction.
- dm_req  in  1  data request; same rules as if_req.
- dm_we  in  1  1 = write, 0 = read.
- dm_digit  in  2  access size: 00 byte, 01 half, 10 word.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  one-cycle completion pulse, for reads and writes.
- dm_rdata  out  DW  read data; 0 on write completion.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_digit  out  2  size to memory.
- mem_addr  out  AW  address to memory.
- mem_wdata  out  DW  write data to memory.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State IDLE, owner NONE, counters 0.
  - All outputs 0.
  - Any in-flight transaction is discarded; no rvalid follows.
- States: IDLE, ACCESS, RESP.
- Acceptance:
  - Allowed only in IDLE or RESP.
  - Grant is combinational: at most one of if_gnt/dm_gnt per cycle.
  - Priority: dm over if, except in the fair build (see Optional Feature).
- Transition to ACCESS:
  - On an accepted edge, register owner, addr, we, digit and wdata (IF: we=0, digit=10).
  - Enter ACCESS with cnt=0.
- ACCESS:
  - mem_en=1, mem_* driven from the registered values.
  - cnt increments each cycle.
  - When cnt==LAT-1, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP:
  - Owner's rvalid=1 for exactly this cycle; the other rvalid stays 0.
  - mem_en=0.
  - If a new request is accepted, go to ACCESS; otherwise go to IDLE.
- rdata registers hold their value until the next capture.
- Latency: grant in cycle t; mem_en high in cycles t+1..t+LAT; rvalid in cycle t+LAT+1.
- Peak throughput: one transaction per LAT+1 cycles.
- Simultaneous if_req and dm_req: dm granted first; IF is granted at the following RESP.
- A request withdrawn before grant is ignored; requests during ACCESS are not granted.
- LAT=1: ACCESS lasts one cycle.
- Addresses and digit pass through unmodified; no alignment check.

Optional Feature:
- Macro MEM_ARB_FAIR_EN.
- Defined:
  - 4-bit wait_cnt increments each cycle if_req=1 and if_gnt=0, saturating at MAX_WAIT.
  - When wait_cnt==MAX_WAIT, IF wins the next arbitration even if dm_req=1.
  - wait_cnt clears on if_gnt, on if_req=0, and on reset.
- Undefined: strict dm priority, no wait_cnt; IF may starve indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - owner enum {NONE, IF, DM};
  - digit constants BYTE=2'b00, HALF=2'b01, WORD=2'b10.
- One sub-module, mem_arb_pick:
  - combinational priority select;
  - includes wait_cnt logic under MEM_ARB_FAIR_EN.
- The FSM and datapath registers stay in the top.

Test Plan:
- LAT=2, IF read: if_req=1 with if_addr=0x10 at t0, mem_rdata=0x00A00093 in cycle t2 -> if_gnt at t0; mem_en at t1..t2 with mem_addr=0x10, mem_we=0; if_rvalid at t3 with if_rdata=0x00A00093.
- DM write: dm_we=1, digit=10, addr=0x40, wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF at t1..t2; dm_rvalid at t3 with dm_rdata=0.
- Both requests at t0 -> dm_gnt at t0; if_gnt at t3 (RESP); if_rvalid at t6.
- Reset low at t1 during ACCESS -> all outputs 0 immediately; no rvalid. After release, a new if_req completes normally.
- MEM_ARB_FAIR_EN, MAX_WAIT=4, dm_req held high and if_req held high -> IF is granted at the first RESP after wait_cnt reaches 4. Without the macro, IF is never granted.
- LAT=1, back-to-back IF requests -> if_rvalid every 2 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational IF/DM grant select; MEM_ARB_FAIR_EN adds an IF wait counter
// that forces IF priority once it has waited MAX_WAIT cycles.
module mem_arb_pick
  import mem_arb_pkg::*;
`ifdef MEM_ARB_FAIR_EN
#(
  parameter int unsigned MAX_WAIT = 4
)
`endif
(
`ifdef MEM_ARB_FAIR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic allow,
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);

  logic if_first;

`ifdef MEM_ARB_FAIR_EN
  logic [WAIT_W-1:0] wait_cnt;

  assign if_first = (wait_cnt == WAIT_W'(MAX_WAIT)) && if_req;

  // Counts cycles IF has been refused; cleared once IF is served or gives up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign if_first = 1'b0;
`endif

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (allow) begin
      if (dm_req && !if_first) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between IF and MEM requesters.
// Build with MEM_ARB_FAIR_EN to bound IF starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LAT      = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [1:0]    dm_digit,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [1:0]    mem_digit,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (LAT < 1 || LAT > 7) begin : g_bad_lat
    $error("mem_port_arbiter: LAT must be 1..7");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
    $error("mem_port_arbiter: MAX_WAIT must be 1..15");
  end

  logic [1:0]       state, state_nx;
  owner_t           owner, owner_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [AW-1:0]    addr_q;
  logic             we_q;
  logic [1:0]       digit_q;
  logic [DW-1:0]    wdata_q;
  logic             allow;
  logic             accept;
  logic             last;

  // Grants are suppressed while reset is asserted so every output reads 0.
  assign allow  = Reset && (state == IDLE || state == RESP);
  assign accept = if_gnt | dm_gnt;
  assign last   = (cnt == CNT_W'(LAT - 1));

  mem_arb_pick
`ifdef MEM_ARB_FAIR_EN
    #(.MAX_WAIT(MAX_WAIT))
`endif
  u_pick (
`ifdef MEM_ARB_FAIR_EN
    .clk    (CLK),
    .rst_n  (Reset),
`endif
    .allow  (allow),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      owner <= OWN_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    cnt_nx   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_nx = ACCESS;
          owner_nx = dm_gnt ? OWN_DM : OWN_IF;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
          owner_nx = OWN_NONE;
        end
      end
      ACCESS: begin
        if (last) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        owner_nx = OWN_NONE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Transaction latch at grant and read-data capture on the last access cycle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      digit_q  <= '0;
      wdata_q  <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= dm_gnt ? dm_addr : if_addr;
        we_q    <= dm_gnt & dm_we;
        digit_q <= dm_gnt ? dm_digit : WORD;
        wdata_q <= dm_gnt ? dm_wdata : '0;
      end
      if (state == ACCESS && last) begin
        if (owner == OWN_IF) begin
          if_rdata <= mem_rdata;
        end else if (owner == OWN_DM) begin
          dm_rdata <= we_q ? '0 : mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_digit = mem_en ? digit_q : 2'b00;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign if_rvalid = (state == RESP) && (owner == OWN_IF);
  assign dm_rvalid = (state == RESP) && (owner == OWN_DM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 instance plus a LAT=1 instance.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [1:0]  dm_digit;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [1:0]  mem_digit;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req_b, dm_req_b, dm_we_b;
  logic [31:0] if_addr_b, dm_addr_b, dm_wdata_b;
  logic [1:0]  dm_digit_b;
  logic        if_gnt_b, if_rvalid_b, dm_gnt_b, dm_rvalid_b;
  logic [31:0] if_rdata_b, dm_rdata_b;
  logic        mem_en_b, mem_we_b;
  logic [1:0]  mem_digit_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return 32'h1234_0000 | {16'h0, a[15:0]};
  endfunction

  assign mem_rdata   = mem_model(mem_addr);
  assign mem_rdata_b = mem_model(mem_addr_b);

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .MAX_WAIT(4)) u_dut (
    .CLK(clk), .Reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_digit(dm_digit), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_digit(mem_digit), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .MAX_WAIT(4)) u_dut_b (
    .CLK(clk), .Reset(rst_n),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_digit(dm_digit_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_gnt(dm_gnt_b), .dm_rvalid(dm_rvalid_b), .dm_rdata(dm_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_digit(mem_digit_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h10; dm_addr = 32'h40;
    @(negedge clk);
    n_cmp++; if (if_gnt !== 1'b0) begin n_err++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
    n_cmp++; if (dm_gnt !== 1'b0) begin n_err++; $display("FAIL rst_dm_gnt: got %b want 0", dm_gnt); end
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_cmp++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", {if_rvalid, dm_rvalid}); end
    n_cmp++; if (if_rdata !== 32'h0) begin n_err++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    if_req = 1'b0; dm_req = 1'b0; if_addr = '0; dm_addr = '0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    n_cmp++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin n_err++; $display("FAIL ifrd_gnt: got if=%b dm=%b want if=1 dm=0", if_gnt, dm_gnt); end
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL ifrd_en_t0: got %b want 0", mem_en); end
    next_cycle();
    if_req = 1'b0; if_addr = '0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL ifrd_en c%0d: got en=%b we=%b want en=1 we=0", c, mem_en, mem_we); end
      n_cmp++; if (mem_addr !== 32'h10 || mem_digit !== 2'b10) begin n_err++; $display("FAIL ifrd_addr c%0d: got %h/%b want 10/10", c, mem_addr, mem_digit); end
      n_cmp++; if (if_rvalid !== 1'b0) begin n_err++; $display("FAIL ifrd_early_rvalid c%0d: got %b want 0", c, if_rvalid); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0) begin n_err++; $display("FAIL ifrd_rvalid: got if=%b dm=%b want if=1 dm=0", if_rvalid, dm_rvalid); end
    n_cmp++; if (if_rdata !== 32'h00A00093) begin n_err++; $display("FAIL ifrd_rdata: got %h want 00a00093", if_rdata); end
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL ifrd_en_resp: got %b want 0", mem_en); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (if_rvalid !== 1'b0) begin n_err++; $display("FAIL ifrd_pulse: got %b want 0", if_rvalid); end
    n_cmp++; if (if_rdata !== 32'h00A00093) begin n_err++; $display("FAIL ifrd_hold: got %h want 00a00093", if_rdata); end
    next_cycle();
  endtask

  task automatic test_dm_write();
    dm_req = 1'b1; dm_we = 1'b1; dm_digit = 2'b10; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL dmwr_gnt: got dm=%b if=%b want dm=1 if=0", dm_gnt, if_gnt); end
    next_cycle();
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_digit = '0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL dmwr_we c%0d: got en=%b we=%b want 1/1", c, mem_en, mem_we); end
      n_cmp++; if (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h40) begin n_err++; $display("FAIL dmwr_data c%0d: got %h@%h want deadbeef@40", c, mem_wdata, mem_addr); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin n_err++; $display("FAIL dmwr_rvalid: got dm=%b if=%b want dm=1 if=0", dm_rvalid, if_rvalid); end
    n_cmp++; if (dm_rdata !== 32'h0) begin n_err++; $display("FAIL dmwr_rdata: got %h want 0", dm_rdata); end
    next_cycle();
  endtask

  task automatic test_both();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_digit = 2'b00; dm_addr = 32'h85;
    @(negedge clk);
    n_cmp++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL both_t0: got dm=%b if=%b want dm=1 if=0", dm_gnt, if_gnt); end
    next_cycle();
    dm_req = 1'b0; dm_addr = '0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++; if (if_gnt !== 1'b0) begin n_err++; $display("FAIL both_no_gnt_access c%0d: got %b want 0", c, if_gnt); end
      n_cmp++; if (mem_addr !== 32'h85 || mem_digit !== 2'b00) begin n_err++; $display("FAIL both_dm_addr c%0d: got %h/%b want 85/00", c, mem_addr, mem_digit); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (dm_rvalid !== 1'b1 || if_gnt !== 1'b1) begin n_err++; $display("FAIL both_t3: got dm_rvalid=%b if_gnt=%b want 1/1", dm_rvalid, if_gnt); end
    n_cmp++; if (dm_rdata !== 32'h12340085) begin n_err++; $display("FAIL both_dm_rdata: got %h want 12340085", dm_rdata); end
    next_cycle();
    if_req = 1'b0; if_addr = '0;
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_addr !== 32'h20 || mem_digit !== 2'b10) begin n_err++; $display("FAIL both_if_addr c%0d: got %h/%b want 20/10", c, mem_addr, mem_digit); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0) begin n_err++; $display("FAIL both_t6: got if=%b dm=%b want if=1 dm=0", if_rvalid, dm_rvalid); end
    n_cmp++; if (if_rdata !== 32'h12340020) begin n_err++; $display("FAIL both_if_rdata: got %h want 12340020", if_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h30;
    @(negedge clk);
    n_cmp++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL rmid_gnt: got %b want 1", if_gnt); end
    next_cycle();
    if_req = 1'b0; if_addr = '0;
    #1;
    n_cmp++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL rmid_pre_en: got %b want 1", mem_en); end
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h30;
    #1;
    n_cmp++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_async: got en=%b addr=%h want 0/0", mem_en, mem_addr); end
    n_cmp++; if (if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin n_err++; $display("FAIL rmid_gnt_low: got if=%b dm=%b want 0/0", if_gnt, dm_gnt); end
    n_cmp++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_err++; $display("FAIL rmid_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    next_cycle();
    rst_n = 1'b1; if_req = 1'b0; if_addr = '0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++; if (if_rvalid !== 1'b0 || mem_en !== 1'b0) begin n_err++; $display("FAIL rmid_discard c%0d: got rvalid=%b en=%b want 0/0", c, if_rvalid, mem_en); end
      next_cycle();
    end
    if_req = 1'b1; if_addr = 32'h30;
    @(negedge clk);
    n_cmp++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL rmid_regnt: got %b want 1", if_gnt); end
    next_cycle();
    if_req = 1'b0; if_addr = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h12340030) begin n_err++; $display("FAIL rmid_after: got rvalid=%b rdata=%h want 1/12340030", if_rvalid, if_rdata); end
    next_cycle();
  endtask

  task automatic test_starve();
    logic exp_if, exp_dm;
    if_req = 1'b1; if_addr = 32'h14;
    dm_req = 1'b1; dm_we = 1'b0; dm_digit = 2'b10; dm_addr = 32'h90;
    for (int c = 0; c <= 8; c++) begin
`ifdef MEM_ARB_FAIR_EN
      exp_dm = (c == 0 || c == 3);
      exp_if = (c == 6);
`else
      exp_dm = (c % 3 == 0);
      exp_if = 1'b0;
`endif
      @(negedge clk);
      n_cmp++; if (if_gnt !== exp_if || dm_gnt !== exp_dm) begin n_err++; $display("FAIL starve c%0d: got if=%b dm=%b want if=%b dm=%b", c, if_gnt, dm_gnt, exp_if, exp_dm); end
      next_cycle();
    end
    if_req = 1'b0; dm_req = 1'b0; if_addr = '0; dm_addr = '0;
    for (int c = 0; c < 3; c++) next_cycle();
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin n_err++; $display("FAIL starve_idle: got en=%b rv=%b%b want 0/00", mem_en, if_rvalid, dm_rvalid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic exp_gnt, exp_rv;
    if_req_b = 1'b1; if_addr_b = 32'h44;
    for (int c = 0; c <= 8; c++) begin
      exp_gnt = (c % 2 == 0);
      exp_rv  = (c >= 2) && (c % 2 == 0);
      @(negedge clk);
      n_cmp++; if (if_gnt_b !== exp_gnt || if_rvalid_b !== exp_rv) begin n_err++; $display("FAIL b2b c%0d: got gnt=%b rvalid=%b want %b/%b", c, if_gnt_b, if_rvalid_b, exp_gnt, exp_rv); end
      if (exp_rv) begin
        n_cmp++; if (if_rdata_b !== 32'h12340044) begin n_err++; $display("FAIL b2b_rdata c%0d: got %h want 12340044", c, if_rdata_b); end
      end
      next_cycle();
    end
    if_req_b = 1'b0; if_addr_b = '0;
    for (int c = 0; c < 3; c++) next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_digit = '0; dm_addr = '0; dm_wdata = '0;
    if_req_b = 1'b0; if_addr_b = '0; dm_req_b = 1'b0; dm_we_b = 1'b0; dm_digit_b = '0; dm_addr_b = '0; dm_wdata_b = '0;
    next_cycle();
    test_reset();
    test_if_read();
    test_dm_write();
    test_both();
    test_reset_mid();
    test_starve();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
